alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer_pkg.sv | 27 ++
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_issuer.sv | 147 ++++++++++++++
 tb/tb_alu_issuer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issuer_pkg.sv
// Shared types for the ALU command issuer: FSM states, opcodes and the queued command record.
// Operand fields are sized for the widest supported WIDTH; narrower builds zero the upper bits.
package alu_issuer_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } opcode_e;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] op1;
    logic [MAX_WIDTH-1:0] op2;
    opcode_e              operation;
    logic                 sign;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Power-of-two command FIFO; pointers wrap naturally, push when full and pop when empty are ignored.
module alu_cmd_fifo #(
  parameter int  DEPTH  = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  data_t                    data_i,
  output data_t                    data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  data_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: contents are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_issuer.sv
// Queues ALU commands, holds operands on the ALU for ALU_WAIT cycles, then returns the result.
// Optional macro ALU_ISSUER_STATS_EN adds a 16-bit completed-response counter (op_count).
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int ALU_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_op1,
  input  logic [WIDTH-1:0]   cmd_op2,
  input  logic [1:0]         cmd_operation,
  input  logic               cmd_sign,
  output logic [WIDTH-1:0]   alu_op1,
  output logic [WIDTH-1:0]   alu_op2,
  output logic [1:0]         alu_operation,
  output logic               alu_sign,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
`ifdef ALU_ISSUER_STATS_EN
  output logic [15:0]        op_count,
`endif
  output state_e             dbg_state_o
);

  localparam int CW = $clog2(ALU_WAIT + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     alu_op1_q, alu_op2_q;
  logic [1:0]           alu_operation_q;
  logic                 alu_sign_q;
  logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic                 pop, load;
  cmd_t                 in_cmd, head;
  logic                 fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 sink_unused;

  always_comb begin
    in_cmd                = '0;
    in_cmd.op1[WIDTH-1:0] = cmd_op1;
    in_cmd.op2[WIDTH-1:0] = cmd_op2;
    in_cmd.operation      = opcode_e'(cmd_operation);
    in_cmd.sign           = cmd_sign;
  end

  alu_cmd_fifo #(.DEPTH(DEPTH), .data_t(cmd_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (pop),
    .data_i  (in_cmd),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready depends on occupancy only, so a pop in a full cycle does not open the door early.
  assign cmd_ready   = (fifo_count < ($clog2(DEPTH)+1)'(DEPTH));
  assign sink_unused = ^{fifo_full, head};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    pop          = 1'b0;
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          cnt_d   = CW'(ALU_WAIT);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rsp_result_d = alu_result;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            cnt_d   = CW'(ALU_WAIT);
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rsp_result_q    <= '0;
      alu_op1_q       <= '0;
      alu_op2_q       <= '0;
      alu_operation_q <= '0;
      alu_sign_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      if (load) begin
        alu_op1_q       <= head.op1[WIDTH-1:0];
        alu_op2_q       <= head.op2[WIDTH-1:0];
        alu_operation_q <= head.operation;
        alu_sign_q      <= head.sign;
      end
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] op_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              op_count_q <= '0;
    else if (state_q == RESP && rsp_ready)   op_count_q <= op_count_q + 16'd1;
  end
  assign op_count = op_count_q;
`endif

  assign alu_op1       = alu_op1_q;
  assign alu_op2       = alu_op2_q;
  assign alu_operation = alu_operation_q;
  assign alu_sign      = alu_sign_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = rsp_result_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: vector table plus latency, fill/backpressure, streaming and reset sequences.
module tb_alu_issuer;
  import alu_issuer_pkg::*;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 4;
  localparam int ALU_WAIT = 1;
  localparam int RW       = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_op1, cmd_op2;
  logic [1:0]       cmd_operation;
  logic             cmd_sign;
  logic [WIDTH-1:0] alu_op1, alu_op2;
  logic [1:0]       alu_operation;
  logic             alu_sign;
  logic [RW-1:0]    alu_result;
  logic             rsp_valid, rsp_ready;
  logic [RW-1:0]    rsp_result;
  state_e           dbg_state;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0]      op_count;
`endif

  alu_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_WAIT(ALU_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .cmd_operation(cmd_operation), .cmd_sign(cmd_sign),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_operation(alu_operation), .alu_sign(alu_sign),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
`ifdef ALU_ISSUER_STATS_EN
    .op_count(op_count),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // combinational ALU attached to the issuer
  logic [RW-1:0] ma, mb;
  always_comb begin
    ma = alu_sign ? {{WIDTH{alu_op1[WIDTH-1]}}, alu_op1} : {{WIDTH{1'b0}}, alu_op1};
    mb = alu_sign ? {{WIDTH{alu_op2[WIDTH-1]}}, alu_op2} : {{WIDTH{1'b0}}, alu_op2};
    case (alu_operation)
      2'd0:    alu_result = ma + mb;
      2'd1:    alu_result = ma - mb;
      2'd2:    alu_result = ma * mb;
      default: alu_result = ma & mb;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int  hs_total  = 0;
  int  last_cyc  = 0;
  int  stream_n  = 0;
  bit  streaming = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got %0h with no response outstanding", rsp_result);
      end else begin
        chk("rsp_result", 64'(rsp_result), 64'(exp_q.pop_front()));
      end
      if (streaming) begin
        if (stream_n > 0) chk("stream_gap", 64'(cyc - last_cyc), 64'(ALU_WAIT + 1));
        stream_n++;
      end
      last_cyc = cyc;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic s);
    int n = 0;
    @(negedge clk);
    cmd_op1 = a; cmd_op2 = b; cmd_operation = op; cmd_sign = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", 64'(n >= 200), 64'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [1:0]       op;
    logic             sign;
    logic [RW-1:0]    exp;
  } vec_t;

  vec_t vecs[10];
  logic [WIDTH-1:0] fa, fb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 2'd0, 1'b0, 32'h0000_0008};
    vecs[1] = '{16'h0003, 16'h0005, 2'd1, 1'b0, 32'hFFFF_FFFE};
    vecs[2] = '{16'h0003, 16'h0005, 2'd1, 1'b1, 32'hFFFF_FFFE};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 2'd2, 1'b0, 32'hFFFE_0001};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 2'd2, 1'b1, 32'h0000_0001};
    vecs[5] = '{16'hFFFF, 16'h0001, 2'd0, 1'b0, 32'h0001_0000};
    vecs[6] = '{16'hFFFF, 16'h0001, 2'd0, 1'b1, 32'h0000_0000};
    vecs[7] = '{16'hF0F0, 16'h3C3C, 2'd3, 1'b0, 32'h0000_3030};
    vecs[8] = '{16'h8000, 16'h0002, 2'd2, 1'b1, 32'hFFFF_0000};
    vecs[9] = '{16'h8000, 16'h0002, 2'd2, 1'b0, 32'h0001_0000};

    // reset with cmd_valid high: must be ignored
    rst_n = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op1 = 16'h1234; cmd_op2 = 16'h4321; cmd_operation = 2'd0; cmd_sign = 1'b0;
    idle_cycles(3);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_alu_op1", 64'(alu_op1), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycles(3);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

    // single command latency: rsp_valid first high ALU_WAIT+2 cycles after the handshake cycle
    exp_q.push_back(32'd8);
    send_cmd(16'd3, 16'd5, 2'd0, 1'b0);
    for (int k = 1; k <= ALU_WAIT + 2; k++) begin
      @(negedge clk);
      chk($sformatf("latency_valid_k%0d", k), 64'(rsp_valid), 64'(k == ALU_WAIT + 2));
    end
    chk("latency_result", 64'(rsp_result), 64'd8);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    // vector table
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_cmd(vecs[i].op1, vecs[i].op2, vecs[i].op, vecs[i].sign);
      wait_drain();
      idle_cycles(3);
      chk($sformatf("v%0d_hold_op1", i), 64'(alu_op1), 64'(vecs[i].op1));
      chk($sformatf("v%0d_hold_op", i), 64'(alu_operation), 64'(vecs[i].op));
      chk($sformatf("v%0d_idle", i), 64'(dbg_state), 64'(IDLE));
    end

    // fill with responses blocked, then backpressure hold
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      fa = WIDTH'(16'h0100 + i);
      fb = WIDTH'(16'h0010 * i);
      exp_q.push_back({{WIDTH{1'b0}}, fa} + {{WIDTH{1'b0}}, fb});
      send_cmd(fa, fb, 2'd0, 1'b0);
    end
    @(negedge clk);
    cmd_op1 = 16'hDEAD; cmd_op2 = 16'hBEEF; cmd_operation = 2'd0; cmd_sign = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(rsp_result), 64'h0100);
      chk("bp_alu_op1", 64'(alu_op1), 64'h0100);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();
    idle_cycles(10);

    // streaming: one response every ALU_WAIT+1 cycles
    stream_n = 0;
    streaming = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fa = WIDTH'(16'h0200 + 3 * i);
      fb = WIDTH'(i);
      exp_q.push_back({{WIDTH{1'b0}}, fa} - {{WIDTH{1'b0}}, fb});
      send_cmd(fa, fb, 2'd1, 1'b0);
    end
    wait_drain();
    idle_cycles(5);
    streaming = 1'b0;
    chk("stream_count", 64'(stream_n), 64'd8);
`ifdef ALU_ISSUER_STATS_EN
    chk("op_count", 64'(op_count), 64'(hs_total));
`endif

    // reset mid-operation while DRIVE with two commands queued
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_q.push_back(32'h0000_2222);
    send_cmd(16'h1111, 16'h1111, 2'd0, 1'b0);
    send_cmd(16'h2222, 16'h0001, 2'd0, 1'b0);
    send_cmd(16'h3333, 16'h0002, 2'd0, 1'b0);
    send_cmd(16'h4444, 16'h0003, 2'd0, 1'b0);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_state", 64'(dbg_state), 64'(DRIVE));
    chk("pre_rst_first_done", 64'(exp_q.size()), 64'd0);
    chk("pre_rst_alu_op1", 64'(alu_op1), 64'h2222);
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op1 = 16'h5555; cmd_op2 = 16'h5555;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("mid_rst_alu_op1", 64'(alu_op1), 64'd0);
    chk("mid_rst_alu_op2", 64'(alu_op2), 64'd0);
    chk("mid_rst_alu_ctl", 64'({alu_operation, alu_sign}), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
`ifdef ALU_ISSUER_STATS_EN
    chk("mid_rst_op_count", 64'(op_count), 64'd0);
`endif
    idle_cycles(2);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("post_rst_no_responses", 64'(seen), 64'd0);
    end
    chk("post_rst2_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst2_state", 64'(dbg_state), 64'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
